psum_writeback: RTL and testbench

Drain stage directly downstream of the corelet's output FIFO. Pops one col-lane partial-sum vector per transfer from the OFIFO and writes it to the partial-sum SRAM (PMEM) at consecutive addresses. In accumulate mode it first reads the existing PMEM word and stores the lane-wise sum. The PMEM contents it writes are what the SFU later consumes.

---
 rtl/psum_wb_pkg.sv | 17 +
 rtl/psum_lane_add.sv | 26 ++
 rtl/psum_writeback.sv | 89 ++++++++
 tb/tb_psum_writeback.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_wb_pkg.sv
// Shared types and sizes for the partial-sum writeback stage.
// Lane geometry, PMEM address width and the writeback FSM state encoding.
package psum_wb_pkg;
    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int ADDR_BW = 11;
    localparam int LANE_W  = PSUM_BW;
    localparam int VEC_BW  = COL * LANE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SUM,
        ST_WRITE,
        ST_FIN
    } state_t;
endpackage

// File: rtl/psum_lane_add.sv
// One signed lane adder; PSUM_SAT_EN selects clamping instead of wraparound.
// Purely combinational; the caller registers the result.
module psum_lane_add
    import psum_wb_pkg::*;
(
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    output logic [LANE_W-1:0] o_sum
);
`ifdef PSUM_SAT_EN
    localparam logic [LANE_W-1:0] MAXV = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] MINV = {1'b1, {(LANE_W-1){1'b0}}};
    logic [LANE_W:0] w_full;

    always_comb begin
        w_full = {i_a[LANE_W-1], i_a} + {i_b[LANE_W-1], i_b};
        // Top two bits disagree only on overflow; the top bit is the true sign.
        if (w_full[LANE_W] != w_full[LANE_W-1])
            o_sum = w_full[LANE_W] ? MINV : MAXV;
        else
            o_sum = w_full[LANE_W-1:0];
    end
`else
    assign o_sum = i_a + i_b;
`endif
endmodule

// File: rtl/psum_writeback.sv
// Drains OFIFO vectors into PMEM at consecutive addresses, optionally read-add-write.
// Optional lane saturation in accumulate mode is enabled by defining PSUM_SAT_EN.
module psum_writeback
    import psum_wb_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_acc,
    input  logic [ADDR_BW-1:0] i_base_addr,
    input  logic [ADDR_BW:0]   i_count,
    input  logic               i_ofifo_valid,
    input  logic [VEC_BW-1:0]  i_ofifo_out,
    output logic               o_ofifo_rd,
    input  logic [VEC_BW-1:0]  i_pmem_q,
    output logic               o_pmem_cen,
    output logic               o_pmem_wen,
    output logic [ADDR_BW-1:0] o_pmem_addr,
    output logic [VEC_BW-1:0]  o_pmem_d,
    output logic               o_busy,
    output logic               o_done
);
    state_t             r_state;
    logic               r_acc;
    logic [ADDR_BW-1:0] r_addr;
    logic [ADDR_BW:0]   r_left;
    logic [VEC_BW-1:0]  r_vec;
    logic [VEC_BW-1:0]  w_sum;
    logic               w_pop;

    genvar g;
    generate
        for (g = 0; g < COL; g++) begin : g_lane
            psum_lane_add u_add (
                .i_a   (r_vec[g*LANE_W +: LANE_W]),
                .i_b   (i_pmem_q[g*LANE_W +: LANE_W]),
                .o_sum (w_sum[g*LANE_W +: LANE_W])
            );
        end
    endgenerate

    // The pop must follow ofifo_valid in the same cycle, so it is decoded from state.
    assign w_pop       = (r_state == ST_FETCH) && i_ofifo_valid;
    assign o_ofifo_rd  = w_pop;
    assign o_pmem_cen  = !((w_pop && r_acc) || (r_state == ST_WRITE));
    assign o_pmem_wen  = (r_state != ST_WRITE);
    assign o_pmem_addr = r_addr;
    assign o_pmem_d    = r_vec;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_FIN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= 1'b0;
            r_addr  <= '0;
            r_left  <= '0;
            r_vec   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_acc   <= i_acc;
                        r_addr  <= i_base_addr;
                        r_left  <= i_count;
                        r_state <= (i_count == '0) ? ST_FIN : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (i_ofifo_valid) begin
                        r_vec   <= i_ofifo_out;
                        r_state <= r_acc ? ST_SUM : ST_WRITE;
                    end
                end
                ST_SUM: begin
                    r_vec   <= w_sum;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_addr  <= r_addr + 1'b1;
                    r_left  <= r_left - 1'b1;
                    r_state <= (r_left == (ADDR_BW+1)'(1)) ? ST_FIN : ST_FETCH;
                end
                ST_FIN: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_writeback.sv
// Bench for psum_writeback: behavioural OFIFO/PMEM models, directed table, corner sequences, random runs.
module tb_psum_writeback;
    import psum_wb_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               acc = 1'b0;
    logic [ADDR_BW-1:0] base_addr = '0;
    logic [ADDR_BW:0]   count = '0;
    logic               ofifo_valid;
    logic [VEC_BW-1:0]  ofifo_out;
    logic               ofifo_rd;
    logic [VEC_BW-1:0]  pmem_q = '0;
    logic               pmem_cen, pmem_wen, busy, done;
    logic [ADDR_BW-1:0] pmem_addr;
    logic [VEC_BW-1:0]  pmem_d;

    psum_writeback dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_acc(acc),
        .i_base_addr(base_addr), .i_count(count),
        .i_ofifo_valid(ofifo_valid), .i_ofifo_out(ofifo_out), .o_ofifo_rd(ofifo_rd),
        .i_pmem_q(pmem_q), .o_pmem_cen(pmem_cen), .o_pmem_wen(pmem_wen),
        .o_pmem_addr(pmem_addr), .o_pmem_d(pmem_d), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    // OFIFO model
    logic [VEC_BW-1:0] fmem [0:63];
    int fhead = 0, ftail = 0;
    logic stall = 1'b0, rstall_en = 1'b0;
    assign ofifo_valid = (fhead != ftail) && !stall;
    assign ofifo_out   = fmem[fhead[5:0]];

    // PMEM model and activity logs
    logic [VEC_BW-1:0] pmem [0:2047];
    int cyc = 0, wn = 0, rn = 0, dn = 0, viol = 0;
    int w_addr [0:255];
    int w_cyc  [0:255];
    logic [VEC_BW-1:0] w_dat [0:255];
    int r_addr [0:255];
    int r_cyc  [0:255];
    int d_cyc  [0:255];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ofifo_rd) begin
            if (!ofifo_valid) viol <= viol + 1;
            fhead <= fhead + 1;
        end
        if (!pmem_cen) begin
            if (!pmem_wen) begin
                pmem[pmem_addr]  <= pmem_d;
                w_addr[wn[7:0]]  <= int'(pmem_addr);
                w_dat[wn[7:0]]   <= pmem_d;
                w_cyc[wn[7:0]]   <= cyc;
                wn <= wn + 1;
            end else begin
                pmem_q          <= pmem[pmem_addr];
                r_addr[rn[7:0]] <= int'(pmem_addr);
                r_cyc[rn[7:0]]  <= cyc;
                rn <= rn + 1;
            end
        end
        if (done) begin
            d_cyc[dn[7:0]] <= cyc;
            dn <= dn + 1;
        end
    end

    always @(negedge clk) stall <= rstall_en && ($urandom_range(0, 2) == 0);

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [VEC_BW-1:0] act, input logic [VEC_BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [VEC_BW-1:0] vec_all(input int v);
        logic [VEC_BW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*PSUM_BW +: PSUM_BW] = v[PSUM_BW-1:0];
        return r;
    endfunction

    // Reference: lane-wise signed add in plain integers, then clamp or wrap.
    function automatic logic [VEC_BW-1:0] ref_vec(input logic a, input logic [VEC_BW-1:0] v,
                                                 input logic [VEC_BW-1:0] old);
        logic [VEC_BW-1:0] r;
        int s;
        for (int i = 0; i < COL; i++) begin
            s = int'($signed(v[i*PSUM_BW +: PSUM_BW])) + int'($signed(old[i*PSUM_BW +: PSUM_BW]));
`ifdef PSUM_SAT_EN
            if (s > (1 << (PSUM_BW-1)) - 1) s = (1 << (PSUM_BW-1)) - 1;
            if (s < -(1 << (PSUM_BW-1)))    s = -(1 << (PSUM_BW-1));
`endif
            r[i*PSUM_BW +: PSUM_BW] = a ? s[PSUM_BW-1:0] : v[i*PSUM_BW +: PSUM_BW];
        end
        return r;
    endfunction

    task automatic push(input logic [VEC_BW-1:0] v);
        fmem[ftail[5:0]] = v;
        ftail = ftail + 1;
    endtask

    task automatic pulse_start(input logic a, input int b, input int n, output int t);
        @(negedge clk);
        start = 1'b1; acc = a; base_addr = b[ADDR_BW-1:0]; count = n[ADDR_BW:0];
        t = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int d0, input int lim);
        for (int i = 0; i < lim && dn == d0; i++) @(negedge clk);
        if (dn == d0) chk({nm, " done timeout"}, 0, 1);
        @(negedge clk); @(negedge clk);
    endtask

    logic [VEC_BW-1:0] vin [0:15];

    task automatic run_case(input string nm, input logic a, input int b, input int n,
                            input logic timed, output int t);
        int w0, r0, d0, p, ea;
        logic [VEC_BW-1:0] eold [0:15];
        w0 = wn; r0 = rn; d0 = dn;
        p = a ? 3 : 2;
        for (int k = 0; k < n; k++) begin
            eold[k] = pmem[(b + k) % 2048];
            push(vin[k]);
        end
        pulse_start(a, b, n, t);
        wait_done(nm, d0, 40 + n * 12);
        chk({nm, " writes"}, wn - w0, n);
        chk({nm, " reads"}, rn - r0, a ? n : 0);
        chk({nm, " dones"}, dn - d0, 1);
        for (int k = 0; k < n && k < wn - w0; k++) begin
            ea = (b + k) % 2048;
            chk($sformatf("%s addr%0d", nm, k), w_addr[(w0 + k) % 256], ea);
            chk($sformatf("%s data%0d", nm, k), w_dat[(w0 + k) % 256], ref_vec(a, vin[k], eold[k]));
            if (timed)
                chk($sformatf("%s wcyc%0d", nm, k), w_cyc[(w0 + k) % 256] - t, (k + 1) * p);
            if (timed && a && k < rn - r0) begin
                chk($sformatf("%s raddr%0d", nm, k), r_addr[(r0 + k) % 256], ea);
                chk($sformatf("%s rd2wr%0d", nm, k), w_cyc[(w0 + k) % 256] - r_cyc[(r0 + k) % 256], 2);
            end
        end
        if (timed && dn > d0) chk({nm, " done cyc"}, d_cyc[d0 % 256] - t, n * p + 1);
    endtask

    typedef struct {
        logic a;
        int   base;
        int   cnt;
        int   vval;
        int   mval;
        int   exp0;
        int   dly;
    } vec_t;
    vec_t tbl [0:4];

    task automatic chk_reset_vals(input string nm);
        chk({nm, " rd"},   ofifo_rd, 0);
        chk({nm, " cen"},  pmem_cen, 1);
        chk({nm, " wen"},  pmem_wen, 1);
        chk({nm, " addr"}, pmem_addr, 0);
        chk({nm, " d"},    pmem_d, 0);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " done"}, done, 0);
    endtask

    initial begin
        int t, w0, r0, d0, f0;
        tbl[0] = '{1'b0,    5, 3,      1,     0,      1, 7};
        tbl[1] = '{1'b1,   10, 1,    -30,   100,     70, 4};
`ifdef PSUM_SAT_EN
        tbl[2] = '{1'b1,   20, 1,      1, 32767,  32767, 4};
        tbl[3] = '{1'b1,   30, 1,     -1, -32768, -32768, 4};
`else
        tbl[2] = '{1'b1,   20, 1,      1, 32767, -32768, 4};
        tbl[3] = '{1'b1,   30, 1,     -1, -32768, 32767, 4};
`endif
        tbl[4] = '{1'b0, 2047, 2,      7,     0,      7, 5};

        #1;
        chk_reset_vals("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].cnt; k++) begin
                pmem[(tbl[i].base + k) % 2048] = vec_all(tbl[i].mval);
                vin[k] = vec_all(tbl[i].vval + k);
            end
            w0 = wn; d0 = dn;
            run_case($sformatf("tbl%0d", i), tbl[i].a, tbl[i].base, tbl[i].cnt, 1'b1, t);
            chk($sformatf("tbl%0d first", i), w_dat[w0 % 256], vec_all(tbl[i].exp0));
            chk($sformatf("tbl%0d dly", i), d_cyc[d0 % 256] - t, tbl[i].dly);
        end

        // Wrap with a 5-cycle empty-FIFO gap between the two vectors
        w0 = wn; r0 = rn; d0 = dn;
        push(vec_all(11));
        pulse_start(1'b0, 2047, 2, t);
        for (int i = 0; i < 20 && wn == w0; i++) @(negedge clk);
        f0 = fhead;
        repeat (5) @(negedge clk);
        chk("gap nopop", fhead - f0, 0);
        chk("gap nowr", wn - w0, 1);
        chk("gap busy", busy, 1);
        push(vec_all(-12));
        wait_done("gap", d0, 20);
        chk("gap writes", wn - w0, 2);
        chk("gap addr0", w_addr[w0 % 256], 2047);
        chk("gap addr1", w_addr[(w0 + 1) % 256], 0);
        chk("gap data1", w_dat[(w0 + 1) % 256], vec_all(-12));

        // count = 0: a done pulse and nothing else, even with a vector waiting
        w0 = wn; r0 = rn; d0 = dn;
        push(vec_all(21));
        f0 = fhead;
        pulse_start(1'b1, 40, 0, t);
        repeat (3) @(negedge clk);
        chk("zero dones", dn - d0, 1);
        chk("zero donecyc", (d_cyc[d0 % 256] - t >= 1) && (d_cyc[d0 % 256] - t <= 2), 1);
        chk("zero nopop", fhead - f0, 0);
        chk("zero noacc", (wn - w0) + (rn - r0), 0);

        // start while busy: second start must not alter mode, base or count
        w0 = wn; r0 = rn; d0 = dn;
        pulse_start(1'b0, 100, 2, t);
        pulse_start(1'b1, 300, 1, t);
        push(vec_all(22));
        wait_done("busy", d0, 30);
        chk("busy writes", wn - w0, 2);
        chk("busy reads", rn - r0, 0);
        chk("busy addr0", w_addr[w0 % 256], 100);
        chk("busy addr1", w_addr[(w0 + 1) % 256], 101);
        chk("busy data0", w_dat[w0 % 256], vec_all(21));
        chk("busy data1", w_dat[(w0 + 1) % 256], vec_all(22));
        chk("busy dones", dn - d0, 1);

        // Reset while in SUM abandons the run
        w0 = wn; d0 = dn;
        pmem[50] = vec_all(5);
        push(vec_all(6));
        pulse_start(1'b1, 50, 1, t);
        @(negedge clk);
        chk("rst pre busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst sum");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst nowr", wn - w0, 0);
        chk("rst nodone", dn - d0, 0);

        // Random runs; cycle timing is only checked when the FIFO never stalls
        for (int r = 0; r < 20; r++) begin
            logic a;
            int b, n;
            logic st;
            a  = 1'($urandom_range(0, 1));
            b  = $urandom_range(0, 2047);
            n  = $urandom_range(1, 6);
            st = 1'(r % 2);
            for (int k = 0; k < n; k++) begin
                vin[k] = {$urandom, $urandom, $urandom, $urandom};
                pmem[(b + k) % 2048] = {$urandom, $urandom, $urandom, $urandom};
            end
            rstall_en = st;
            run_case($sformatf("rnd%0d", r), a, b, n, !st, t);
            rstall_en = 1'b0;
            @(negedge clk);
        end

        chk("pop while empty", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
